// File: rtl/mdu_pipe.sv
// mdu_pipe: E-stage multiply/divide unit owning the HI/LO registers.
//
// Executes MULT/MULTU/DIV/DIVU over a configurable number of cycles and
// MTHI/MTLO in a single edge. The full result is computed from the operands
// sampled on the issue edge into shadow registers. It is committed to HI/LO
// on the last busy edge.
//
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// When it is undefined, op codes 7-10 behave as NOP.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   reset  - asynchronous, active-low reset
//   start  - issue strobe; op/A/B are sampled on the edge where start=1
//   op     - operation code (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//            6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NOP)
//   A, B   - forwarded operands rs / rt
//   hi, lo - HI/LO registers (pure register outputs)
//   busy   - high while a multi-cycle operation is in flight
module mdu_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  // How the shadow value is applied to {hi,lo} on the commit edge.
  typedef enum logic [1:0] {CM_LOAD, CM_KEEP, CM_ADD, CM_SUB} commit_t;

  state_t            state, state_nx;
  logic [CW-1:0]     counter;
  logic [WIDTH-1:0]  sh_hi, sh_lo;
  commit_t           sh_mode;

  // Issue-side datapath
  logic [2*WIDTH-1:0] sa2, sb2, ua2, ub2, sprod, uprod;
  logic signed [WIDTH-1:0] sdvd, sdvs, squot, srem;
  logic [WIDTH-1:0]   udvs, uquot, urem;
  logic               sovf;
  logic               issue_run;
  logic [CW-1:0]      issue_cycles;
  logic [2*WIDTH-1:0] res;
  commit_t            res_mode;

  always_comb begin
    // Low 2W bits of the product of extended operands equal the exact
    // signed/unsigned product modulo 2^(2W).
    sa2   = {{WIDTH{A[WIDTH-1]}}, A};
    sb2   = {{WIDTH{B[WIDTH-1]}}, B};
    ua2   = {{WIDTH{1'b0}}, A};
    ub2   = {{WIDTH{1'b0}}, B};
    sprod = sa2 * sb2;
    uprod = ua2 * ub2;

    // MIN / -1 is resolved explicitly; the divisor is forced to 1 in that
    // case and for B=0 so the dividers never see an undefined operation.
    sovf  = (A == SMIN) && (B == '1);
    sdvd  = $signed(A);
    sdvs  = (B == '0 || sovf) ? WIDTH'(1) : $signed(B);
    squot = sdvd / sdvs;
    srem  = sdvd % sdvs;
    udvs  = (B == '0) ? WIDTH'(1) : B;
    uquot = A / udvs;
    urem  = A % udvs;
  end

  always_comb begin
    issue_run    = 1'b0;
    issue_cycles = '0;
    res          = '0;
    res_mode     = CM_LOAD;
    unique case (op)
      OP_MULT: begin
        issue_run    = 1'b1;
        issue_cycles = CW'(MULT_CYCLES);
        res          = sprod;
      end
      OP_MULTU: begin
        issue_run    = 1'b1;
        issue_cycles = CW'(MULT_CYCLES);
        res          = uprod;
      end
      OP_DIV: begin
        issue_run    = 1'b1;
        issue_cycles = CW'(DIV_CYCLES);
        if (B == '0)   res_mode = CM_KEEP;
        else if (sovf) res = {{WIDTH{1'b0}}, SMIN};
        else           res = {srem, squot};
      end
      OP_DIVU: begin
        issue_run    = 1'b1;
        issue_cycles = CW'(DIV_CYCLES);
        if (B == '0) res_mode = CM_KEEP;
        else         res = {urem, uquot};
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        issue_run    = 1'b1;
        issue_cycles = CW'(MULT_CYCLES);
        res          = (op == OP_MADD || op == OP_MSUB) ? sprod : uprod;
        res_mode     = (op == OP_MADD || op == OP_MADDU) ? CM_ADD : CM_SUB;
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && issue_run) state_nx = RUN;
      RUN:  if (counter == CW'(1))  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath registers: counter, shadows, HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      sh_hi   <= '0;
      sh_lo   <= '0;
      sh_mode <= CM_LOAD;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) hi <= A;
            if (op == OP_MTLO) lo <= A;
            if (issue_run) begin
              sh_hi   <= res[2*WIDTH-1:WIDTH];
              sh_lo   <= res[WIDTH-1:0];
              sh_mode <= res_mode;
              counter <= issue_cycles;
            end
          end
        end
        RUN: begin
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            unique case (sh_mode)
              CM_LOAD: {hi, lo} <= {sh_hi, sh_lo};
`ifdef MDU_MADD_EN
              // Accumulate against {hi,lo} as it stands on the commit edge.
              CM_ADD:  {hi, lo} <= {hi, lo} + {sh_hi, sh_lo};
              CM_SUB:  {hi, lo} <= {hi, lo} - {sh_hi, sh_lo};
`endif
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// Self-checking bench for mdu_pipe (default parameters, WIDTH=32).
module tb_mdu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] A, B;
  logic [W-1:0] hi, lo;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference HI/LO
  logic [W-1:0] mhi, mlo;

  always #5 clk = ~clk;

  mdu_pipe #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .hi(hi), .lo(lo), .busy(busy)
  );

  // Reference model: architectural effect of one op, plus its busy length.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             output int n);
    longint sa, sb, ma, mb, qm, rm;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = 0;
    case (o)
      4'd1: begin p = sa * sb; {mhi, mlo} = p; n = 5; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; n = 5; end
      4'd3: begin
        n = 10;
        if (b != 0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          qm = ma / mb;
          rm = ma % mb;
          if ((sa < 0) != (sb < 0)) qm = -qm;
          if (sa < 0) rm = -rm;
          mlo = qm[31:0];
          mhi = rm[31:0];
        end
      end
      4'd4: begin
        n = 10;
        if (b != 0) begin mlo = a / b; mhi = a % b; end
      end
      4'd5: mhi = a;
      4'd6: mlo = a;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        if (o == 4'd7 || o == 4'd9) p = sa * sb;
        else                        p = {32'd0, a} * {32'd0, b};
        acc = {mhi, mlo};
        if (o <= 4'd8) acc = acc + p;
        else           acc = acc - p;
        {mhi, mlo} = acc;
        n = 5;
      end
`endif
      default: ;
    endcase
  endtask

  // Drives one issue and measures busy length; held=0 if hi/lo moved while busy.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
    nb = 0; held = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    if (busy) nb = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 4'd0; A = '0; B = '0;
    #12;
    total++;
    if ({busy, hi, lo} !== {1'b0, 64'd0})
      begin bad++; $display("FAIL reset: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo); end
    mhi = '0; mlo = '0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    int en, nb; bit held;
    model_apply(4'd1, 32'hFFFFFFFD, 32'd5, en);
    run_op(4'd1, 32'hFFFFFFFD, 32'd5, nb, held);
    total++;
    if (nb !== 5 || !held)
      begin bad++; $display("FAIL mult_busy: cycles=%0d held=%0d, required 5/1", nb, held); end
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1)
      begin bad++; $display("FAIL mult_result: hi=%h lo=%h, required ffffffff/fffffff1", hi, lo); end
  endtask

  task automatic test_divide();
    int en, nb; bit held;
    model_apply(4'd4, 32'd100, 32'd7, en);
    run_op(4'd4, 32'd100, 32'd7, nb, held);
    total++;
    if (nb !== 10 || !held)
      begin bad++; $display("FAIL divu_busy: cycles=%0d held=%0d, required 10/1", nb, held); end
    total++;
    if (hi !== 32'd2 || lo !== 32'd14)
      begin bad++; $display("FAIL divu_result: hi=%h lo=%h, required 00000002/0000000e", hi, lo); end
    model_apply(4'd3, 32'hFFFFFFF9, 32'd2, en);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, nb, held);
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || nb !== 10)
      begin bad++; $display("FAIL div_signed: hi=%h lo=%h cycles=%0d, required ffffffff/fffffffd/10", hi, lo, nb); end
  endtask

  task automatic test_div_zero();
    int en, nb; bit held;
    model_apply(4'd5, 32'h1234, 32'd0, en);
    run_op(4'd5, 32'h1234, 32'd0, nb, held);
    model_apply(4'd6, 32'h5678, 32'd0, en);
    run_op(4'd6, 32'h5678, 32'd0, nb, held);
    total++;
    if (nb !== 0 || hi !== 32'h1234 || lo !== 32'h5678)
      begin bad++; $display("FAIL mthi_mtlo: hi=%h lo=%h cycles=%0d, required 1234/5678/0", hi, lo, nb); end
    model_apply(4'd3, 32'd9, 32'd0, en);
    run_op(4'd3, 32'd9, 32'd0, nb, held);
    total++;
    if (nb !== 10 || !held)
      begin bad++; $display("FAIL divzero_busy: cycles=%0d held=%0d, required 10/1", nb, held); end
    total++;
    if (hi !== 32'h1234 || lo !== 32'h5678)
      begin bad++; $display("FAIL divzero_keep: hi=%h lo=%h, required 00001234/00005678", hi, lo); end
    model_apply(4'd3, 32'h80000000, 32'hFFFFFFFF, en);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, nb, held);
    total++;
    if (hi !== 32'd0 || lo !== 32'h80000000)
      begin bad++; $display("FAIL div_min_neg1: hi=%h lo=%h, required 00000000/80000000", hi, lo); end
  endtask

  task automatic test_ignore_start();
    int en, nb;
    model_apply(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, en);
    @(negedge clk);
    start = 1'b1; op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    nb = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (nb == 2) begin start = 1'b1; op = 4'd6; A = 32'd7; end
      else begin start = 1'b0; op = 4'd0; end
    end
    start = 1'b0; op = 4'd0;
    if (busy) nb = -1;
    total++;
    if (nb !== 5)
      begin bad++; $display("FAIL ignore_busy: cycles=%0d, required 5", nb); end
    total++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
      begin bad++; $display("FAIL ignore_result: hi=%h lo=%h, required fffffffe/00000001", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int nb; bit ok;
    @(negedge clk);
    start = 1'b1; op = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    #2 reset = 1'b0;
    #1;
    mhi = '0; mlo = '0;
    total++;
    if (nb !== 3 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      begin bad++; $display("FAIL reset_mid: cycles=%0d busy=%b hi=%h lo=%h, required 3/0/0/0", nb, busy, hi, lo); end
    #3 reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    total++;
    if (!ok)
      begin bad++; $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo); end
  endtask

  task automatic test_madd();
    int en, nb; bit held;
    model_apply(4'd5, 32'd0, 32'd0, en);  run_op(4'd5, 32'd0, 32'd0, nb, held);
    model_apply(4'd6, 32'd10, 32'd0, en); run_op(4'd6, 32'd10, 32'd0, nb, held);
    model_apply(4'd7, 32'd3, 32'd4, en);  run_op(4'd7, 32'd3, 32'd4, nb, held);
`ifdef MDU_MADD_EN
    total++;
    if (nb !== 5 || hi !== 32'd0 || lo !== 32'd22)
      begin bad++; $display("FAIL madd: cycles=%0d hi=%h lo=%h, required 5/00000000/00000016", nb, hi, lo); end
    model_apply(4'd10, 32'd5, 32'd5, en); run_op(4'd10, 32'd5, 32'd5, nb, held);
    total++;
    if (nb !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      begin bad++; $display("FAIL msubu: cycles=%0d hi=%h lo=%h, required 5/ffffffff/fffffffd", nb, hi, lo); end
`else
    total++;
    if (nb !== 0 || hi !== 32'd0 || lo !== 32'd10)
      begin bad++; $display("FAIL madd_disabled: cycles=%0d hi=%h lo=%h, required 0/00000000/0000000a", nb, hi, lo); end
`endif
  endtask

  // Random ops issued back to back, each on the first idle cycle after the previous one.
  task automatic test_back_to_back();
    int en, nb; bit held;
    logic [3:0] o; logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        default: ;
      endcase
      model_apply(o, a, b, en);
      run_op(o, a, b, nb, held);
      total++;
      if (nb !== en || !held)
        begin bad++; $display("FAIL rand_busy op=%0d: cycles=%0d held=%0d, required %0d/1", o, nb, held, en); end
      total++;
      if (hi !== mhi || lo !== mlo)
        begin bad++; $display("FAIL rand_result op=%0d a=%h b=%h: hi=%h lo=%h, required %h/%h", o, a, b, hi, lo, mhi, mlo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divide();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit for the next pipeline generation; sits in the E stage beside the ALU.
- Owns the HI/LO registers and executes multiply, divide and HI/LO moves over a configurable number of cycles.
- Drives busy so hazard control stalls D-stage MDU instructions while an operation is in flight.
- Forwarded operands arrive already resolved by the E-stage forwarding muxes.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥8).
- MULT_CYCLES, 5, busy cycles for multiply-class ops (≥1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe; op/A/B are sampled on the edge where start=1.
- op  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; all others are NOP.
- A  input  WIDTH  operand rs (forwarded).
- B  input  WIDTH  operand rt (forwarded).
- hi  output  WIDTH  current HI register (for MFHI).
- lo  output  WIDTH  current LO register (for MFLO).
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0.
  - State goes to IDLE, counter=0, shadow registers=0.
  - Any in-flight operation is discarded; HI/LO are not updated.
- States: IDLE, RUN.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (or lo) takes A on that edge.
  - No busy cycle; the state stays IDLE.
- IDLE, start=1, mult/div-class op:
  - Full result is computed from the sampled A/B into shadow registers sh_hi/sh_lo.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES; state goes to RUN.
- RUN:
  - busy=1; counter decrements each edge.
  - On the edge where counter==1: hi<=sh_hi, lo<=sh_lo, state goes to IDLE, busy falls.
- Timing: start sampled at edge k gives busy=1 during cycles k+1..k+N, and new hi/lo are visible after edge k+N. hi/lo keep their old values until that edge.
- start while busy=1: ignored. Hazard control must not issue; the bench checks that hi/lo/counter are unaffected.
- start with NOP/unknown op: no effect.
- MULT: signed 2·WIDTH product; hi=upper half, lo=lower half.
- MULTU: same as MULT, unsigned.
- DIV (signed): lo=quotient truncated toward zero; hi=remainder with the sign of the dividend (A).
  - A=MIN, B=-1: lo=MIN, hi=0; no trap.
- DIVU: unsigned quotient/remainder.
- B=0 on DIV/DIVU: full DIV_CYCLES busy, then hi and lo are left unchanged.
- MADD/MADDU/MSUB/MSUBU: only when MDU_MADD_EN is defined (see below).
- Arithmetic is modulo 2^(2·WIDTH) on {hi,lo}.
- hi/lo are pure register outputs, with no combinational path from A/B/op.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD/MADDU: {hi,lo} <= {hi,lo} + (A×B), signed/unsigned.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} − (A×B), signed/unsigned.
  - The accumulate base is the {hi,lo} value at commit time; these ops use MULT_CYCLES.
- Undefined: op codes 7–10 are treated as NOP (no busy, no update); no accumulate hardware is synthesised.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (−3), B=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy=0 next cycle.
- DIVU A=100, B=7 → 10 busy cycles; lo=0x0000000E, hi=0x00000002. Then DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV A=9, B=0 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged. Also DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- Mid-operation checks:
  - Start MULTU A=B=0xFFFFFFFF; at busy cycle 2 pulse start with MTLO A=7 → ignored; final hi=0xFFFFFFFE, lo=0x00000001.
  - Repeat the MULTU, then assert reset=0 at busy cycle 3 → immediately hi=lo=0, busy=0; release and stay idle with no late commit.
- MDU_MADD_EN defined:
  - MTHI 0, MTLO 10, MADD A=3, B=4 → lo=22, hi=0.
  - MSUBU A=5, B=5 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MDU_MADD_EN undefined: the same MADD sequence → no busy, hi=0, lo=10.
